nitc_mem_unit: RTL and testbench

Unified instruction/data memory for the NITC-RISC24 multicycle core, replacing the core's internal word array with a handshaked, wait-stated memory. It sits directly behind the core's memory port: fetch, load and store requests come in, and read data is returned to the instruction register/MDR path. A boot port streams the program image in after reset and holds the core off via `core_run` until loading completes.

---
 rtl/nitc_pkg.sv | 22 ++
 rtl/nitc_mem_unit_ram.sv | 27 ++
 rtl/nitc_mem_unit.sv | 203 ++++++++++++++++++++
 tb/tb_nitc_mem_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nitc_pkg.sv
// Shared definitions for the NITC-RISC24 memory subsystem: word width,
// memory-unit state encoding and the default memory map constants.
package nitc_pkg;

  localparam int WORD_W              = 16;
  localparam int DEFAULT_DEPTH       = 256;
  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam logic [WORD_W-1:0] PCSTART = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_IDLE = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } mem_state_t;

  // Zero-extended compare so DEPTH=65536 covers the full 16-bit address space.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int depth);
    return ({16'h0000, addr} < 32'(depth));
  endfunction

endpackage

// File: rtl/nitc_mem_unit_ram.sv
// Single-port word RAM: one synchronous write port, one asynchronous read port.
module nitc_sp_ram
  import nitc_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Synchronous write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/nitc_mem_unit.sv
// Unified instruction/data memory with a boot loader port and a wait-stated
// single-outstanding request handshake toward the multicycle core.
module nitc_mem_unit
  import nitc_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  input  logic              boot_valid,
  input  logic [WORD_W-1:0] boot_data,
  input  logic              boot_done,
  output logic              core_run,
  output logic              err_oob
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_FULL  = PW'(DEPTH);
  localparam logic [3:0]    WAIT_INIT = 4'(WAIT_CYCLES);

  mem_state_t        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              lat_write_q, lat_write_d;
  logic [WORD_W-1:0] lat_addr_q, lat_addr_d;
  logic [WORD_W-1:0] lat_wdata_q, lat_wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              core_run_q, core_run_d;
  logic              err_oob_q, err_oob_d;

  logic              c_write_s;
  logic [WORD_W-1:0] c_addr_s;
  logic [WORD_W-1:0] c_wdata_s;
  logic              c_inrange_s;
  logic              commit_s;
  logic              ram_we_s;
  logic [AW-1:0]     ram_waddr_s;
  logic [WORD_W-1:0] ram_wdata_s;
  logic [WORD_W-1:0] ram_rdata_s;

  nitc_sp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (c_addr_s[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  // With zero wait states the commit happens on the accept edge, so the live request is used.
  always_comb begin
    c_write_s = lat_write_q;
    c_addr_s  = lat_addr_q;
    c_wdata_s = lat_wdata_q;
    if (state_q == ST_IDLE) begin
      c_write_s = req_write;
      c_addr_s  = req_addr;
      c_wdata_s = req_wdata;
    end else begin
      c_write_s = lat_write_q;
      c_addr_s  = lat_addr_q;
      c_wdata_s = lat_wdata_q;
    end
    c_inrange_s = addr_in_range(c_addr_s, DEPTH);
  end

  // Next-state, boot/commit write mux and registered output computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    err_oob_d   = err_oob_q;
    commit_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_waddr_s = c_addr_s[AW-1:0];
    ram_wdata_s = c_wdata_s;

    case (state_q)
      ST_BOOT: begin
        if (boot_valid) begin
          if (ptr_q != PTR_FULL) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = ptr_q[AW-1:0];
            ram_wdata_s = boot_data;
            ptr_d       = ptr_q + PW'(1'b1);
          end else begin
            err_oob_d = 1'b1;
          end
        end else begin
          ptr_d = ptr_q;
        end
        if (boot_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BOOT;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          lat_write_d = req_write;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d  = ST_RESP;
          cnt_d    = 4'd0;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (commit_s) begin
      if (!c_inrange_s) begin
        rsp_rdata_d = 16'h0000;
        err_oob_d   = 1'b1;
      end else if (c_write_s) begin
        ram_we_s    = 1'b1;
        rsp_rdata_d = 16'h0000;
      end else begin
        rsp_rdata_d = ram_rdata_s;
      end
    end else begin
      rsp_rdata_d = rsp_rdata_d;
    end

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    core_run_d  = (state_d != ST_BOOT);
  end

  // State and output registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      ptr_q       <= '0;
      cnt_q       <= 4'd0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= 16'h0000;
      lat_wdata_q <= 16'h0000;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      core_run_q  <= 1'b0;
      err_oob_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      core_run_q  <= core_run_d;
      err_oob_q   <= err_oob_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign core_run  = core_run_q;
  assign err_oob   = err_oob_q;

endmodule

// File: tb/tb_nitc_mem_unit.sv
// Directed bench for nitc_mem_unit: three instances (W=2/D=256, W=0/D=256,
// W=2/D=16) share clock, reset and data buses but have private valid strobes.
module tb_nitc_mem_unit;
  import nitc_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid_v;
  logic [2:0]  boot_valid_v;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] boot_data;
  logic        boot_done;
  logic [2:0]  ready_v, rspv_v, run_v, oob_v;
  logic [15:0] rdata0, rdata1, rdata2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    logic        oob;
  } vec_t;
  vec_t tbl [12];

  nitc_mem_unit #(.DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_v[0]),
    .rsp_valid(rspv_v[0]), .rsp_rdata(rdata0), .boot_valid(boot_valid_v[0]),
    .boot_data(boot_data), .boot_done(boot_done), .core_run(run_v[0]), .err_oob(oob_v[0]));

  nitc_mem_unit #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_v[1]),
    .rsp_valid(rspv_v[1]), .rsp_rdata(rdata1), .boot_valid(boot_valid_v[1]),
    .boot_data(boot_data), .boot_done(boot_done), .core_run(run_v[1]), .err_oob(oob_v[1]));

  nitc_mem_unit #(.DEPTH(16), .WAIT_CYCLES(2)) u_d16 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[2]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_v[2]),
    .rsp_valid(rspv_v[2]), .rsp_rdata(rdata2), .boot_valid(boot_valid_v[2]),
    .boot_data(boot_data), .boot_done(boot_done), .core_run(run_v[2]), .err_oob(oob_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rdata_of(input int k);
    case (k)
      0:       return rdata0;
      1:       return rdata1;
      default: return rdata2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One request on instance k; checks latency and the single-cycle pulse.
  task automatic do_req(input int k, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int exp_lat, output logic [15:0] rd);
    int n;
    @(negedge clk);
    chk("ready_before_accept", 32'(ready_v[k]), 32'd1);
    req_valid_v[k] = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid_v = 3'b000;
    req_write   = ~wr;
    req_addr    = ~addr;
    req_wdata   = ~wdata;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rspv_v[k]) break;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    rd = rdata_of(k);
    @(negedge clk);
    chk("rsp_pulse_one_cycle", 32'(rspv_v[k]), 32'd0);
  endtask

  initial begin
    logic [15:0] rd;
    int pulses;

    tbl[0]  = '{1'b0, 16'h0000, 16'h0000, 16'hA001, 1'b0};
    tbl[1]  = '{1'b0, 16'h0003, 16'h0000, 16'hA004, 1'b0};
    tbl[2]  = '{1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0};
    tbl[4]  = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0};
    tbl[5]  = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};
    tbl[6]  = '{1'b1, 16'h00FF, 16'h5A5A, 16'h0000, 1'b0};
    tbl[7]  = '{1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0};
    tbl[8]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
    tbl[9]  = '{1'b1, 16'h0100, 16'hDEAD, 16'h0000, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 16'hA001, 1'b1};
    tbl[11] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};

    req_valid_v  = 3'b000;
    boot_valid_v = 3'b000;
    req_write    = 1'b0;
    req_addr     = 16'h0000;
    req_wdata    = 16'h0000;
    boot_data    = 16'h0000;
    boot_done    = 1'b0;
    reset        = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_ready", 32'(ready_v), 32'd0);
    chk("rst_rspv", 32'(rspv_v), 32'd0);
    chk("rst_run", 32'(run_v), 32'd0);
    chk("rst_oob", 32'(oob_v), 32'd0);
    chk("rst_rdata", {rdata0, rdata1 | rdata2}, 32'd0);
    reset = 1'b0;

    // Boot: 4 words into the 256-deep units, 17 words into the 16-deep one.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      boot_valid_v = (i < 4) ? 3'b111 : 3'b100;
      boot_data    = 16'hA001 + 16'(i);
    end
    @(negedge clk);
    boot_valid_v = 3'b000;
    chk("boot_run_low", 32'(run_v), 32'd0);
    chk("boot_ready_low", 32'(ready_v), 32'd0);
    chk("boot_oob", 32'(oob_v), 32'b100);
    boot_done = 1'b1;
    @(negedge clk);
    boot_done = 1'b0;
    chk("boot_run_high", 32'(run_v), 32'd7);
    chk("boot_oob_after", 32'(oob_v), 32'b100);
    chk("idle_ready", 32'(ready_v), 32'd7);

    // WAIT_CYCLES=2 read of addr 2: three not-ready cycles, pulse in the third.
    @(negedge clk);
    req_valid_v[0] = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0002;
    @(posedge clk);
    #1;
    req_valid_v = 3'b000;
    req_addr    = 16'h0000;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk("w2_ready_seq", 32'(ready_v[0]), 32'(n == 4));
      chk("w2_rspv_seq", 32'(rspv_v[0]), 32'(n == 3));
      if (n == 3) begin
        chk("w2_rdata", 32'(rdata0), 32'hA003);
      end
    end

    // Table of WAIT_CYCLES=0 transactions.
    for (int i = 0; i < 12; i++) begin
      do_req(1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1, rd);
      chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_oob", i), 32'(oob_v[1]), 32'(tbl[i].oob));
    end
    chk("w2_oob_clear", 32'(oob_v[0]), 32'd0);

    // DEPTH=16 overflow: words 0..15 kept, 17th dropped, no wrap.
    do_req(2, 1'b0, 16'h000F, 16'h0000, 3, rd);
    chk("d16_last", 32'(rd), 32'hA010);
    do_req(2, 1'b0, 16'h0000, 16'h0000, 3, rd);
    chk("d16_first", 32'(rd), 32'hA001);
    do_req(2, 1'b0, 16'h0010, 16'h0000, 3, rd);
    chk("d16_oob_rd", 32'(rd), 32'h0000);

    // Reset mid-WAIT during a write to addr 7.
    do_req(0, 1'b1, 16'h0007, 16'h0707, 3, rd);
    chk("w2_wr_rdata", 32'(rd), 32'h0000);
    do_req(0, 1'b0, 16'h0007, 16'h0000, 3, rd);
    chk("w2_rd7", 32'(rd), 32'h0707);
    @(negedge clk);
    req_valid_v[0] = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0007;
    req_wdata = 16'h7777;
    @(posedge clk);
    #1;
    req_valid_v = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midwait_state", 32'(u_w2.state_q == ST_BOOT), 32'd1);
    chk("midwait_run", 32'(run_v), 32'd0);
    chk("midwait_oob", 32'(oob_v), 32'd0);
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rspv_v[0]) pulses++;
    end
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (rspv_v[0]) pulses++;
    end
    chk("midwait_no_rsp", 32'(pulses), 32'd0);
    chk("midwait_boot_ready", 32'(ready_v[0]), 32'd0);
    boot_done = 1'b1;
    @(negedge clk);
    boot_done = 1'b0;
    chk("reboot_run", 32'(run_v), 32'd7);
    do_req(0, 1'b0, 16'h0007, 16'h0000, 3, rd);
    chk("midwait_ram7", 32'(rd), 32'h0707);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
